// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit timer: default timing
// parameters, derived widths and the sample-point action classifier.
package usb_rx_pkg;

  localparam int USB_CLKS_PER_BIT  = 8;
  localparam int USB_SAMPLE_POINT  = 4;
  localparam int USB_STUFF_LEN     = 6;
  localparam int USB_BITS_PER_WORD = 8;

  // Widths derived from the default timing.
  localparam int PH_W  = $clog2(USB_CLKS_PER_BIT);
  localparam int RUN_W = $clog2(USB_STUFF_LEN + 1);
  localparam int BC_W  = $clog2(USB_BITS_PER_WORD);

  // What happens to a sampled bit.
  typedef enum logic [1:0] {
    ACT_SHIFT = 2'd0,
    ACT_SKIP  = 2'd1,
    ACT_ERROR = 2'd2
  } bit_action_e;

  // A full run of 1s means the next bit must be a stuffed 0; anything
  // else is a stuffing violation. Otherwise the bit is shifted in.
  function automatic bit_action_e classify(input logic b, input logic run_full);
    bit_action_e act;
    if (run_full) begin
      act = b ? ACT_ERROR : ACT_SKIP;
    end else begin
      act = ACT_SHIFT;
    end
    return act;
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer_if.sv
// Connection between the line edge detector / RCU side and the bit timer.
interface usb_rx_bit_timer_if
  import usb_rx_pkg::*;
#(
  parameter int CNT_W = BC_W
);
  logic             d_edge;
  logic             receiving;
  logic             shift_enable;
  logic             rx_bit;
  logic             byte_received;
  logic             stuff_skip;
  logic             stuff_error;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output d_edge, receiving,
    input  shift_enable, rx_bit, byte_received, stuff_skip, stuff_error, bit_count
  );

  modport slave (
    input  d_edge, receiving,
    output shift_enable, rx_bit, byte_received, stuff_skip, stuff_error, bit_count
  );
endinterface

// File: rtl/usb_rx_bit_timer_flex_counter.sv
// Flexible rollover counter: counts 0..rollover_val-1 on count_enable and
// wraps to 0; rollover_flag marks the last count value.
module flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS:0]   rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = ({1'b0, count_out} == (rollover_val - (NUM_CNT_BITS + 1)'(1)));

  // Count register: clear has priority over counting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_out <= '0;
      end else begin
        count_out <= count_out + NUM_CNT_BITS'(1);
      end
    end else begin
      count_out <= count_out;
    end
  end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// USB receive bit timer: recovers bit timing from line edges, decodes
// NRZI, removes stuffed bits and strobes the RX shift register.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = USB_SAMPLE_POINT,
  parameter int BITS_PER_WORD = USB_BITS_PER_WORD,
  parameter int STUFF_LEN     = USB_STUFF_LEN
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_bit_timer_if.slave  rx
);

  localparam int PHASE_W = $clog2(CLKS_PER_BIT);
  localparam int RUNL_W  = $clog2(STUFF_LEN + 1);
  localparam int CNT_W   = $clog2(BITS_PER_WORD);

  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
  localparam logic [RUNL_W-1:0]  RUN_FULL     = RUNL_W'(STUFF_LEN);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("usb_rx_bit_timer: CLKS_PER_BIT must be >= 4");
    end
    if ((SAMPLE_POINT < 1) || (SAMPLE_POINT > CLKS_PER_BIT - 1)) begin : g_bad_sp
      $error("usb_rx_bit_timer: SAMPLE_POINT must be in 1..CLKS_PER_BIT-1");
    end
    if (BITS_PER_WORD < 2) begin : g_bad_bpw
      $error("usb_rx_bit_timer: BITS_PER_WORD must be >= 2");
    end
    if (STUFF_LEN < 1) begin : g_bad_stuff
      $error("usb_rx_bit_timer: STUFF_LEN must be >= 1");
    end
  endgenerate

  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [RUNL_W-1:0]  run, run_nxt;
  logic               edge_seen, edge_seen_nxt;
  logic               strobe;
  bit_action_e        action;

  logic shift_nxt, bit_nxt, byte_nxt, skip_nxt, err_nxt;
  logic shift_q, bit_q, byte_q, skip_q, err_q;

  logic [CNT_W-1:0] count;
  logic             rollover;

  // Next-state for phase, run length, edge memory and the output pulses.
  always_comb begin
    phase_nxt     = phase;
    run_nxt       = run;
    edge_seen_nxt = edge_seen;
    strobe        = 1'b0;
    action        = ACT_SHIFT;
    shift_nxt     = 1'b0;
    bit_nxt       = 1'b0;
    skip_nxt      = 1'b0;
    err_nxt       = 1'b0;
    if (!rx.receiving) begin
      phase_nxt     = '0;
      run_nxt       = '0;
      edge_seen_nxt = 1'b0;
    end else begin
      // An edge in the sample cycle moves the bit centre, so no sample then.
      strobe = (phase == PHASE_SAMPLE) && !rx.d_edge;

      // The edge cycle counts as phase 0, so the register resumes at 1.
      if (rx.d_edge) begin
        phase_nxt = PHASE_W'(1);
      end else if (phase == PHASE_LAST) begin
        phase_nxt = '0;
      end else begin
        phase_nxt = phase + PHASE_W'(1);
      end

      if (rx.d_edge) begin
        edge_seen_nxt = 1'b1;
      end else if (strobe) begin
        edge_seen_nxt = 1'b0;
      end else begin
        edge_seen_nxt = edge_seen;
      end

      // NRZI: a transition within the bit time decodes as 0.
      if (strobe) begin
        action = classify(!edge_seen, run == RUN_FULL);
        case (action)
          ACT_SHIFT: begin
            shift_nxt = 1'b1;
            bit_nxt   = !edge_seen;
            run_nxt   = edge_seen ? '0 : run + RUNL_W'(1);
          end
          ACT_SKIP: begin
            skip_nxt = 1'b1;
            run_nxt  = '0;
          end
          ACT_ERROR: begin
            err_nxt = 1'b1;
            run_nxt = '0;
          end
          default: begin
            run_nxt = '0;
          end
        endcase
      end else begin
        run_nxt = run;
      end
    end
    byte_nxt = shift_nxt && rollover;
  end

  // Timing state and registered output pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase     <= '0;
      run       <= '0;
      edge_seen <= 1'b0;
      shift_q   <= 1'b0;
      bit_q     <= 1'b0;
      byte_q    <= 1'b0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      run       <= run_nxt;
      edge_seen <= edge_seen_nxt;
      shift_q   <= shift_nxt;
      bit_q     <= bit_nxt;
      byte_q    <= byte_nxt;
      skip_q    <= skip_nxt;
      err_q     <= err_nxt;
    end
  end

  // Word bit counter advances on the same edge that raises shift_enable.
  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!rx.receiving),
    .count_enable  (shift_nxt),
    .rollover_val  ((CNT_W + 1)'(BITS_PER_WORD)),
    .count_out     (count),
    .rollover_flag (rollover)
  );

  assign rx.shift_enable  = shift_q;
  assign rx.rx_bit        = bit_q;
  assign rx.byte_received = byte_q;
  assign rx.stuff_skip    = skip_q;
  assign rx.stuff_error   = err_q;
  assign rx.bit_count     = count;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Directed bench for usb_rx_bit_timer (8 clocks/bit, sample at 4,
// 8 bits/word, stuff after 6 ones).
module tb_usb_rx_bit_timer;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  usb_rx_bit_timer_if #(.CNT_W(3)) rx_if ();

  usb_rx_bit_timer #(
    .CLKS_PER_BIT  (8),
    .SAMPLE_POINT  (4),
    .BITS_PER_WORD (8),
    .STUFF_LEN     (6)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx_if.slave)
  );

  // Per bit time: edge at its first cycle, expected pulses
  // {shift_enable, rx_bit, byte_received, stuff_skip, stuff_error}
  // seen after the sample point, and bit_count after that bit.
  typedef struct {
    logic       edge_in;
    logic [4:0] pulses;
    logic [2:0] bc;
  } vec_t;

  vec_t tbl[26];

  function automatic logic [7:0] observed();
    return {rx_if.shift_enable, rx_if.rx_bit, rx_if.byte_received,
            rx_if.stuff_skip, rx_if.stuff_error, rx_if.bit_count};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = observed();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {se,bit,byte,skip,err,bc}=%b required %b", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, clock, then compare outputs.
  task automatic cyc(input logic e, input logic r, input logic [7:0] exp, input string name);
    rx_if.d_edge    = e;
    rx_if.receiving = r;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // One 8-cycle bit time with receiving high.
  task automatic run_bit(input logic e, input logic [4:0] p, input logic [2:0] bc,
                         input logic [2:0] prev_bc, input string name);
    logic [7:0] exp;
    for (int j = 0; j < 8; j++) begin
      if (j == 4) exp = {p, bc};
      else if (j < 4) exp = {5'b00000, prev_bc};
      else exp = {5'b00000, bc};
      cyc((j == 0) && e, 1'b1, exp, name);
    end
  endtask

  initial begin
    logic [2:0] prev;
    logic [7:0] exp;

    // Eight bits of edges, then a stuffed 0, then a stuff error.
    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 5'b10000, 3'(i + 1)};
    tbl[7]  = '{1'b1, 5'b10100, 3'd0};
    tbl[8]  = '{1'b1, 5'b10000, 3'd1};
    for (int i = 9; i < 15; i++) tbl[i] = '{1'b0, 5'b11000, 3'(i - 7)};
    tbl[15] = '{1'b1, 5'b00010, 3'd7};
    tbl[16] = '{1'b1, 5'b10100, 3'd0};
    for (int i = 17; i < 23; i++) tbl[i] = '{1'b0, 5'b11000, 3'(i - 16)};
    tbl[23] = '{1'b0, 5'b00001, 3'd6};
    tbl[24] = '{1'b0, 5'b11000, 3'd7};
    tbl[25] = '{1'b1, 5'b10100, 3'd0};

    rx_if.d_edge    = 1'b0;
    rx_if.receiving = 1'b0;
    n_rst           = 1'b0;
    #12;
    check("reset", 8'h00);
    n_rst = 1'b1;

    // Not receiving: edges are ignored.
    for (int i = 0; i < 50; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 8'h00, "idle");

    // Table: receiving rises with the first bit time.
    prev = 3'd0;
    for (int i = 0; i < 26; i++) begin
      run_bit(tbl[i].edge_in, tbl[i].pulses, tbl[i].bc, prev, $sformatf("tbl%0d", i));
      prev = tbl[i].bc;
    end

    // Early edge at phase 6 resyncs: sample 4 cycles later, not at phase slot.
    for (int k = 0; k < 14; k++) begin
      if (k == 4) exp = 8'b10000_001;
      else if (k == 10) exp = 8'b10000_010;
      else if (k < 4) exp = 8'b00000_000;
      else if (k < 10) exp = 8'b00000_001;
      else exp = 8'b00000_010;
      cyc((k == 0) || (k == 6), 1'b1, exp, $sformatf("resync%0d", k));
    end

    // Edge landing on the sample phase suppresses that strobe.
    for (int m = 0; m < 10; m++) begin
      if (m == 8) exp = 8'b10000_011;
      else if (m < 8) exp = 8'b00000_010;
      else exp = 8'b00000_011;
      cyc(m == 4, 1'b1, exp, $sformatf("suppress%0d", m));
    end

    // Mid-byte abort via receiving.
    cyc(1'b0, 1'b0, 8'h00, "abort_clr");
    for (int i = 0; i < 5; i++) run_bit(1'b1, 5'b10000, 3'(i + 1), 3'(i), "pre_abort");
    cyc(1'b0, 1'b0, 8'h00, "abort");
    for (int i = 0; i < 3; i++) run_bit(1'b1, 5'b10000, 3'(i + 1), 3'(i), "post_abort");

    // Asynchronous reset while a shift pulse is showing.
    for (int j = 0; j < 4; j++) cyc(j == 0, 1'b1, 8'b00000_011, "pre_rst");
    cyc(1'b0, 1'b1, 8'b10000_100, "pre_rst_shift");
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst", 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold", 8'h00);
    @(negedge clk);
    n_rst = 1'b1;
    run_bit(1'b1, 5'b10000, 3'd1, 3'd0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
